// File: rtl/hex_seg_pkg.sv
// Shared constants for the hex seven-segment scanner: the nibble-to-segment
// table (g..a, active-low), the all-dark pattern and the digit-index width.
package hex_seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Bits needed to hold a digit index 0..num_digits-1 (never less than 1).
   function automatic int idx_width(input int num_digits);
      return (num_digits > 1) ? $clog2(num_digits) : 1;
   endfunction

endpackage

// File: rtl/hex_7seg_scan_if.sv
// Bus between the scanner and its user: load/value/blank_mask in,
// segment and digit-enable drive plus pending status out.
interface hex_7seg_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   value;
   logic [NUM_DIGITS-1:0]     blank_mask;
   logic [6:0]                seg;
   logic [NUM_DIGITS-1:0]     dig_en;
   logic                      pending;

   modport master (
      output load, value, blank_mask,
      input  seg, dig_en, pending
   );

   modport slave (
      input  load, value, blank_mask,
      output seg, dig_en, pending
   );
endinterface

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to seven-segment (g..a, active-low) decoder.
module hex_seg_lut
   import hex_seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/hex_7seg_scan.sv
// Multiplexed hex display scanner. A prescaler steps the active digit every
// PRESCALE clocks; new data is staged in a shadow register and only moved to
// the display register at the frame boundary so a frame never mixes values.
// Optional macro HEX_7SEG_SCAN_LZB_EN enables leading-zero blanking.
module hex_7seg_scan
   import hex_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000
) (
   input  logic            clk,
   input  logic            rst,
   hex_7seg_scan_if.slave  bus
);

   localparam int             IW       = idx_width(NUM_DIGITS);
   localparam int             CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int             VW       = 4 * NUM_DIGITS;
   localparam logic [CW-1:0]  CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]          cnt_q,         cnt_d;
   logic [IW-1:0]          idx_q,         idx_d;
   logic [VW-1:0]          shadow_val_q,  shadow_val_d;
   logic [NUM_DIGITS-1:0]  shadow_mask_q, shadow_mask_d;
   logic [VW-1:0]          disp_val_q,    disp_val_d;
   logic [NUM_DIGITS-1:0]  disp_mask_q,   disp_mask_d;
   logic                   pending_q,     pending_d;
   logic [6:0]             seg_q,         seg_d;
   logic [NUM_DIGITS-1:0]  dig_en_q,      dig_en_d;

   logic                   tick;
   logic                   frame_end;
   logic [3:0]             cur_nib;
   logic                   cur_blank;
   logic [6:0]             lut_seg;

   // Pick the displayed nibble and its blanking for the current digit.
   always_comb begin
      cur_nib   = 4'h0;
      cur_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cur_nib   = disp_val_q[4*k +: 4];
            cur_blank = disp_mask_q[k];
         end
      end
`ifdef HEX_7SEG_SCAN_LZB_EN
      begin : lzb
         logic lead_zero;
         lead_zero = 1'b1;
         // Walk down from the top digit; digit 0 is never reached.
         for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lead_zero = lead_zero & (disp_val_q[4*k +: 4] == 4'h0);
            if ((idx_q == IW'(k)) && lead_zero) cur_blank = 1'b1;
         end
      end
`endif
   end

   hex_seg_lut u_lut (
      .nib_i (cur_nib),
      .seg_o (lut_seg)
   );

   // Next-state: prescaler, digit index, shadow/display hand-over, outputs.
   always_comb begin
      // NOTE: every _d takes its hold value first, so no branch can leave one
      // unassigned and infer a latch.
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      shadow_val_d  = shadow_val_q;
      shadow_mask_d = shadow_mask_q;
      disp_val_d    = disp_val_q;
      disp_mask_d   = disp_mask_q;
      pending_d     = pending_q;

      tick      = (cnt_q == CNT_LAST);
      frame_end = tick && (idx_q == IDX_LAST);

      if (tick) begin
         cnt_d = '0;
         idx_d = frame_end ? '0 : idx_q + IW'(1);
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      // The old shadow moves first; a coinciding load then refills it.
      if (frame_end && pending_q) begin
         disp_val_d  = shadow_val_q;
         disp_mask_d = shadow_mask_q;
         pending_d   = 1'b0;
      end
      if (bus.load) begin
         shadow_val_d  = bus.value;
         shadow_mask_d = bus.blank_mask;
         pending_d     = 1'b1;
      end

      // Outputs follow the current index, so they lag a tick by one clock.
      seg_d = cur_blank ? SEG_OFF : lut_seg;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         dig_en_d[k] = (idx_q != IW'(k));
      end
   end

   // State register with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      if (rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         shadow_val_q  <= '0;
         shadow_mask_q <= '0;
         disp_val_q    <= '0;
         disp_mask_q   <= '0;
         pending_q     <= 1'b0;
         seg_q         <= SEG_OFF;
         dig_en_q      <= '1;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_val_q  <= shadow_val_d;
         shadow_mask_q <= shadow_mask_d;
         disp_val_q    <= disp_val_d;
         disp_mask_q   <= disp_mask_d;
         pending_q     <= pending_d;
         seg_q         <= seg_d;
         dig_en_q      <= dig_en_d;
      end
   end

   assign bus.seg     = seg_q;
   assign bus.dig_en  = dig_en_q;
   assign bus.pending = pending_q;

endmodule

// File: tb/tb_hex_7seg_scan.sv
// Bench for hex_7seg_scan (PRESCALE=4, NUM_DIGITS=4): a cycle-count model of
// the display checked every cycle, plus directed literal expectations.
// Build with HEX_7SEG_SCAN_LZB_EN defined to exercise leading-zero blanking.
module tb_hex_7seg_scan;

   localparam int P     = 4;
   localparam int N     = 4;
   localparam int FRAME = P * N;

   logic clk;
   logic rst;

   hex_7seg_scan_if #(.NUM_DIGITS(N)) bus ();

   hex_7seg_scan #(
      .NUM_DIGITS (N),
      .PRESCALE   (P)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [6:0] seg_ref [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // e counts clock edges since reset release; the digit on screen and the
   // frame boundaries follow from e by plain arithmetic.
   int          e;
   int          m_d;
   logic [15:0] m_shadow_val, m_disp_val;
   logic [3:0]  m_shadow_mask, m_disp_mask;
   logic        m_pend;
   logic [6:0]  exp_seg;
   logic [3:0]  exp_dig;

   function automatic logic [6:0] model_seg(input logic [15:0] v, input logic [3:0] m, input int d);
      logic [15:0] upper;
      upper = v >> (4 * d);
      if (m[2'(d)]) return 7'h7F;
`ifdef HEX_7SEG_SCAN_LZB_EN
      if ((d > 0) && (upper == '0)) return 7'h7F;
`endif
      return seg_ref[upper[3:0]];
   endfunction

   task automatic model_reset();
      e = 0;
      m_shadow_val = '0; m_shadow_mask = '0;
      m_disp_val = '0;   m_disp_mask = '0;
      m_pend = 1'b0;
      exp_seg = 7'h7F;
      exp_dig = 4'hF;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_reset();
         end else begin
            m_d     = (e / P) % N;
            exp_dig = ~(4'b0001 << m_d);
            exp_seg = model_seg(m_disp_val, m_disp_mask, m_d);
            if (((e % FRAME) == FRAME - 1) && m_pend) begin
               m_disp_val  = m_shadow_val;
               m_disp_mask = m_shadow_mask;
               m_pend      = 1'b0;
            end
            if (bus.load) begin
               m_shadow_val  = bus.value;
               m_shadow_mask = bus.blank_mask;
               m_pend        = 1'b1;
            end
            e++;
         end
      end
   end

   // Compare process: every falling edge outside reset.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("model_seg",     16'(bus.seg),     16'(exp_seg));
            check("model_dig_en",  16'(bus.dig_en),  16'(exp_dig));
            check("model_pending", 16'(bus.pending), 16'(m_pend));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic at_phase(input int ph);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((e % FRAME) != ph) && (n < 200));
      if ((e % FRAME) != ph) begin
         total++;
         bad++;
         $display("FAIL phase_wait: got %0d want %0d", e % FRAME, ph);
      end
   endtask

   task automatic drive(input logic [15:0] v, input logic [3:0] m);
      bus.load       = 1'b1;
      bus.value      = v;
      bus.blank_mask = m;
      @(negedge clk);
      bus.load       = 1'b0;
   endtask

   task automatic lit(input string name, input logic [6:0] s, input logic [3:0] d);
      check({name, "_seg"}, 16'(bus.seg),    16'(s));
      check({name, "_dig"}, 16'(bus.dig_en), 16'(d));
   endtask

   logic [3:0] dig_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [6:0] seg_12af [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
   logic [6:0] lz_hi;

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      bus.load = 1'b0;
      bus.value = '0;
      bus.blank_mask = '0;
`ifdef HEX_7SEG_SCAN_LZB_EN
      lz_hi = 7'h7F;
`else
      lz_hi = 7'h40;
`endif

      repeat (3) @(negedge clk);
      check("reset_seg", 16'(bus.seg), 16'h007F);
      check("reset_dig", 16'(bus.dig_en), 16'h000F);
      #2 rst = 1'b0;
      @(negedge clk);
      lit("release", 7'h40, 4'hE);
      check("release_pend", 16'(bus.pending), 16'h0000);

      // 12AF scan order and hold time
      drive(16'h12AF, 4'h0);
      check("load_pend", 16'(bus.pending), 16'h0001);
      at_phase(1);
      check("12af_pend", 16'(bus.pending), 16'h0000);
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < P; j++) begin
            lit("12af", seg_12af[k], dig_seq[k]);
            @(negedge clk);
         end
      end

      // mid-frame load keeps the old frame intact
      at_phase(6);
      drive(16'h1234, 4'h0);
      check("mid_pend", 16'(bus.pending), 16'h0001);
      at_phase(10);
      lit("mid_old2", 7'h24, 4'hB);
      at_phase(14);
      lit("mid_old3", 7'h79, 4'h7);
      check("mid_pend3", 16'(bus.pending), 16'h0001);
      at_phase(1);
      lit("mid_new0", 7'h19, 4'hE);
      check("mid_pend_clr", 16'(bus.pending), 16'h0000);
      at_phase(5);
      lit("mid_new1", 7'h30, 4'hD);

      // load coinciding with the boundary while a load is pending
      at_phase(6);
      drive(16'h5678, 4'h0);
      at_phase(15);
      drive(16'hBEEF, 4'h0);
      check("bnd_pend0", 16'(bus.pending), 16'h0001);
      at_phase(1);
      lit("bnd_5678_0", 7'h00, 4'hE);
      check("bnd_pend1", 16'(bus.pending), 16'h0001);
      at_phase(13);
      lit("bnd_5678_3", 7'h12, 4'h7);
      at_phase(1);
      lit("beef_0", 7'h0E, 4'hE);
      check("beef_pend", 16'(bus.pending), 16'h0000);
      at_phase(5);
      lit("beef_1", 7'h06, 4'hD);
      at_phase(13);
      lit("beef_3", 7'h03, 4'h7);

      // blank mask
      at_phase(6);
      drive(16'h8888, 4'b0101);
      at_phase(1);  lit("mask0", 7'h7F, 4'hE);
      at_phase(5);  lit("mask1", 7'h00, 4'hD);
      at_phase(9);  lit("mask2", 7'h7F, 4'hB);
      at_phase(13); lit("mask3", 7'h00, 4'h7);

      // leading zeros
      at_phase(6);
      drive(16'h0050, 4'h0);
      at_phase(1);  lit("lz0", 7'h40, 4'hE);
      at_phase(5);  lit("lz1", 7'h12, 4'hD);
      at_phase(9);  lit("lz2", lz_hi, 4'hB);
      at_phase(13); lit("lz3", lz_hi, 4'h7);

      // asynchronous reset at idx 2 with a load pending
      at_phase(6);
      drive(16'hCAFE, 4'h0);
      at_phase(10);
      check("arst_pre_pend", 16'(bus.pending), 16'h0001);
      #2 rst = 1'b1;
      #1;
      lit("arst", 7'h7F, 4'hF);
      check("arst_pend", 16'(bus.pending), 16'h0000);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      lit("arst_rel", 7'h40, 4'hE);
      check("arst_rel_pend", 16'(bus.pending), 16'h0000);

      // randomized traffic against the model, with one reset in the middle
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         bus.load       = ($urandom_range(0, 7) == 0);
         bus.value      = 16'($urandom);
         bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         if (i == 400) begin
            #2 rst = 1'b1;
            #1;
            lit("rnd_arst", 7'h7F, 4'hF);
            @(negedge clk);
            #2 rst = 1'b0;
         end
      end
      @(negedge clk);
      bus.load = 1'b0;
      repeat (2 * FRAME) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hex_7seg_scan.md
HEX_7SEG_SCAN -- requirements
Module: hex_7seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 SHALL have parameter PRESCALE, default 50000, clk cycles per digit slot; legal range 2..2^20.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit: capture value and blank_mask this cycle.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS bits: hex nibbles; nibble k drives digit k, digit 0 is rightmost.
REQ-007 SHALL have port blank_mask, input, NUM_DIGITS bits: bit k=1 forces digit k dark.
REQ-008 SHALL have port seg, output, 7 bits: segments g..a (bit6=g), active-low.
REQ-009 SHALL have port dig_en, output, NUM_DIGITS bits: digit enables, active-low, at most one bit low.
REQ-010 SHALL have port pending, output, 1 bit: high while a loaded value awaits a frame boundary.

Function
REQ-011 SHALL use a prescale counter that counts 0..PRESCALE-1 and asserts tick for one cycle when it reaches PRESCALE-1, then wraps to 0.
REQ-012 SHALL advance digit index idx on tick: idx -> idx+1, and NUM_DIGITS-1 -> 0; the wrap is the frame boundary.
REQ-013 SHALL hold a shadow register (value, mask) and a display register; load=1 writes shadow and sets pending=1 on the same edge.
REQ-014 SHALL copy shadow to display and clear pending at the frame-boundary edge if pending=1, so a frame never mixes old and new data.
REQ-015 SHALL, when load and the frame boundary coincide, copy the old shadow to display, capture the new input into shadow, and keep pending=1.
REQ-016 SHALL decode the display nibble at idx with the encoding 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18 A:08 B:03 C:46 D:21 E:06 F:0E (hex, g..a, active-low).
REQ-017 SHALL register seg and dig_en; both reflect a new idx exactly 1 clk after the tick edge.
REQ-018 SHALL drive seg=7'h7F for a blanked digit while dig_en for that digit stays low.
REQ-019 SHALL keep dig_en one-hot-cold at all times after reset; no cycle SHALL exist with two digits enabled.

Reset
REQ-020 SHALL, while rst=1, asynchronously force counter=0, idx=0, shadow=0, display=0, pending=0, seg=7'h7F and dig_en all ones.
REQ-021 SHALL, on rst deassertion, show digit 0 (seg=7'h40, dig_en bit0 low) from the first clk edge after deassertion.
REQ-022 SHALL, when rst is asserted mid-frame, discard any pending load.

Configuration
REQ-023 SHALL support macro HEX_7SEG_SCAN_LZB_EN; when defined, each display digit k>0 whose nibble and all higher nibbles are 0 SHALL be blanked (seg=7'h7F); digit 0 SHALL never be blanked by this rule.
REQ-024 SHALL, without HEX_7SEG_SCAN_LZB_EN, show leading zeros, so only blank_mask blanks digits.

Structure
REQ-025 SHALL place the 16-entry segment constant table, the SEG_OFF constant (7'h7F) and the digit-index width function in a shared package hex_seg_pkg.
REQ-026 SHALL implement decoding in one combinational sub-module hex_seg_lut (4-bit in, 7-bit out) instantiated once.

Verification
REQ-027 SHALL cover: PRESCALE=4, NUM_DIGITS=4, load value=16'h12AF -> dig_en sequence E,D,B,7 with seg 0E,08,24,79, each held 4 clk.
REQ-028 SHALL cover: load 16'h1234 mid-frame at idx=1 -> pending=1; digits 1..3 still show old data; pending=0 and the first 1234 digit appear after the idx 3->0 wrap.
REQ-029 SHALL cover: load pulse on the boundary edge, then a second load 16'hBEEF -> old shadow shown next frame, BEEF the frame after; pending stays high across the first boundary.
REQ-030 SHALL cover: blank_mask=4'b0101, value=16'h8888 -> digits 0 and 2 show seg=7F; digits 1 and 3 show 00.
REQ-031 SHALL cover: with LZB_EN, value=16'h0050 -> digit 3 shows 7F, digit 2 shows 7F, digit 1 shows 12, digit 0 shows 40; without LZB_EN digits 3 and 2 show 40.
REQ-032 SHALL cover: rst asserted at idx=2 with pending=1 -> seg=7F and dig_en=F immediately without a clk; after release, idx=0, pending=0 and seg=40.
